crop_video_cfg_ctrl: RTL and testbench



---
 rtl/crop_video_cfg_ctrl_if.sv | 27 ++
 rtl/crop_video_cfg_ctrl.sv | 154 +++++++++++++++
 tb/tb_crop_video_cfg_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/crop_video_cfg_ctrl_if.sv
// rtl/crop_video_cfg_ctrl_if.sv - crop-window request handshake bus
interface crop_video_cfg_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_x;
  logic [15:0] cfg_y;
  logic [15:0] cfg_w;
  logic [15:0] cfg_h;

  modport master (
    output cfg_valid,
    output cfg_x,
    output cfg_y,
    output cfg_w,
    output cfg_h,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_x,
    input  cfg_y,
    input  cfg_w,
    input  cfg_h,
    output cfg_ready
  );
endinterface

// File: rtl/crop_video_cfg_ctrl.sv
// rtl/crop_video_cfg_ctrl.sv - crop window sequencer, commits checked windows on start-of-frame
// Optional: CROP_VIDEO_CFG_CLAMP_EN clamps illegal windows instead of dropping them.
module crop_video_cfg_ctrl #(
  parameter int FRAME_W = 1920,
  parameter int FRAME_H = 1080,
  parameter int RST_X   = 0,
  parameter int RST_Y   = 0,
  parameter int RST_W   = FRAME_W,
  parameter int RST_H   = FRAME_H
) (
  input  logic                       clk,
  input  logic                       rst,
  crop_video_cfg_ctrl_if.slave       cfg,
  input  logic                       cfg_flush,
  input  logic                       sof,
  output logic [15:0]                crop_x,
  output logic [15:0]                crop_y,
  output logic [15:0]                crop_width,
  output logic [15:0]                crop_height,
  output logic                       cfg_pending,
  output logic                       cfg_applied,
  output logic                       cfg_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CHECK   = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;

  localparam logic [16:0] FW17 = 17'(FRAME_W);
  localparam logic [16:0] FH17 = 17'(FRAME_H);

  logic [1:0]  state;
  logic        ready_q;
  logic [15:0] req_x, req_y, req_w, req_h;
  logic [15:0] shd_x, shd_y, shd_w, shd_h;

  logic        chk_legal;
  logic        chk_take;
  logic [15:0] win_x, win_y, win_w, win_h;
  logic [16:0] sum_x, sum_y;

  assign cfg.cfg_ready = ready_q;

  // Sums are widened to 17 bits so e.g. x=65535,w=1 cannot wrap into range.
  assign sum_x = {1'b0, req_x} + {1'b0, req_w};
  assign sum_y = {1'b0, req_y} + {1'b0, req_h};

  assign chk_legal = (req_w != 16'd0) && (req_h != 16'd0) &&
                     (sum_x <= FW17) && (sum_y <= FH17);

`ifdef CROP_VIDEO_CFG_CLAMP_EN
  localparam logic [15:0] FW_MAX = 16'(FRAME_W - 1);
  localparam logic [15:0] FH_MAX = 16'(FRAME_H - 1);

  logic [15:0] w_min1, h_min1, room_x, room_y;

  always_comb begin
    win_x  = ({1'b0, req_x} >= FW17) ? FW_MAX : req_x;
    win_y  = ({1'b0, req_y} >= FH17) ? FH_MAX : req_y;
    w_min1 = (req_w == 16'd0) ? 16'd1 : req_w;
    h_min1 = (req_h == 16'd0) ? 16'd1 : req_h;
    // Room to the right/bottom edge is always >= 1 once x/y are clamped.
    room_x = 16'(FW17 - {1'b0, win_x});
    room_y = 16'(FH17 - {1'b0, win_y});
    win_w  = (w_min1 > room_x) ? room_x : w_min1;
    win_h  = (h_min1 > room_y) ? room_y : h_min1;
    chk_take = 1'b1;
  end
`else
  always_comb begin
    win_x    = req_x;
    win_y    = req_y;
    win_w    = req_w;
    win_h    = req_h;
    chk_take = chk_legal;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      req_x       <= 16'd0;
      req_y       <= 16'd0;
      req_w       <= 16'd0;
      req_h       <= 16'd0;
      shd_x       <= 16'd0;
      shd_y       <= 16'd0;
      shd_w       <= 16'd0;
      shd_h       <= 16'd0;
      crop_x      <= 16'(RST_X);
      crop_y      <= 16'(RST_Y);
      crop_width  <= 16'(RST_W);
      crop_height <= 16'(RST_H);
      cfg_pending <= 1'b0;
      cfg_applied <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_applied <= 1'b0;
      cfg_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_valid && ready_q) begin
            req_x   <= cfg.cfg_x;
            req_y   <= cfg.cfg_y;
            req_w   <= cfg.cfg_w;
            req_h   <= cfg.cfg_h;
            ready_q <= 1'b0;
            state   <= CHECK;
          end else begin
            ready_q <= 1'b1;
          end
        end
        CHECK: begin
          cfg_err <= !chk_legal;
          if (chk_take) begin
            shd_x       <= win_x;
            shd_y       <= win_y;
            shd_w       <= win_w;
            shd_h       <= win_h;
            cfg_pending <= 1'b1;
            state       <= PENDING;
          end else begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        PENDING: begin
          // Flush has priority so a discarded window never reaches the cropper.
          if (cfg_flush) begin
            cfg_pending <= 1'b0;
            ready_q     <= 1'b1;
            state       <= IDLE;
          end else if (sof) begin
            crop_x      <= shd_x;
            crop_y      <= shd_y;
            crop_width  <= shd_w;
            crop_height <= shd_h;
            cfg_applied <= 1'b1;
            cfg_pending <= 1'b0;
            ready_q     <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          ready_q     <= 1'b0;
          cfg_pending <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crop_video_cfg_ctrl.sv
// tb/tb_crop_video_cfg_ctrl.sv - directed self-checking bench for crop_video_cfg_ctrl
module tb_crop_video_cfg_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_flush = 1'b0;
  logic        sof = 1'b0;
  logic [15:0] crop_x, crop_y, crop_width, crop_height;
  logic        cfg_pending, cfg_applied, cfg_err;
  logic [63:0] crop_all;
  logic [63:0] exp_crop;
  int          errors = 0;
  int          checks = 0;

  crop_video_cfg_ctrl_if cfg_bus ();

  crop_video_cfg_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfg_bus.slave),
    .cfg_flush   (cfg_flush),
    .sof         (sof),
    .crop_x      (crop_x),
    .crop_y      (crop_y),
    .crop_width  (crop_width),
    .crop_height (crop_height),
    .cfg_pending (cfg_pending),
    .cfg_applied (cfg_applied),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  assign crop_all = {crop_x, crop_y, crop_width, crop_height};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the CHECK cycle of the request.
  task automatic send_req(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] w, input logic [15:0] h);
    for (int i = 0; i < 20 && !cfg_bus.cfg_ready; i++) tick();
    checks++;
    if (cfg_bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout got %b exp 1", cfg_bus.cfg_ready);
    end
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_x = x;
    cfg_bus.cfg_y = y;
    cfg_bus.cfg_w = w;
    cfg_bus.cfg_h = h;
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (crop_all !== {16'd0, 16'd0, 16'd1920, 16'd1080}) begin errors++; $display("FAIL reset_crop got %h exp %h", crop_all, {16'd0, 16'd0, 16'd1920, 16'd1080}); end
    checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b exp 0", cfg_bus.cfg_ready); end
    checks++; if ({cfg_pending, cfg_applied, cfg_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {cfg_pending, cfg_applied, cfg_err}); end
    rst = 1'b1;
    tick();
    checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b exp 1", cfg_bus.cfg_ready); end
    exp_crop = {16'd0, 16'd0, 16'd1920, 16'd1080};
  endtask

  task automatic test_basic();
    send_req(16'd100, 16'd50, 16'd640, 16'd480);
    checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL basic_check_ready got %b exp 0", cfg_bus.cfg_ready); end
    tick();
    checks++; if ({cfg_pending, cfg_err, cfg_bus.cfg_ready} !== 3'b100) begin errors++; $display("FAIL basic_pending got %b exp 100", {cfg_pending, cfg_err, cfg_bus.cfg_ready}); end
    sof = 1'b1;
    tick();
    sof = 1'b0;
    exp_crop = {16'd100, 16'd50, 16'd640, 16'd480};
    checks++; if (crop_all !== exp_crop) begin errors++; $display("FAIL basic_commit got %h exp %h", crop_all, exp_crop); end
    checks++; if ({cfg_applied, cfg_bus.cfg_ready, cfg_pending} !== 3'b110) begin errors++; $display("FAIL basic_applied got %b exp 110", {cfg_applied, cfg_bus.cfg_ready, cfg_pending}); end
    tick();
    checks++; if (cfg_applied !== 1'b0) begin errors++; $display("FAIL basic_applied_pulse got %b exp 0", cfg_applied); end
  endtask

  task automatic test_illegal();
    send_req(16'd1800, 16'd0, 16'd200, 16'd100);
    tick();
`ifdef CROP_VIDEO_CFG_CLAMP_EN
    checks++; if ({cfg_err, cfg_pending} !== 2'b11) begin errors++; $display("FAIL illegal_clamp_flags got %b exp 11", {cfg_err, cfg_pending}); end
    sof = 1'b1;
    tick();
    sof = 1'b0;
    exp_crop = {16'd1800, 16'd0, 16'd120, 16'd100};
    checks++; if (crop_all !== exp_crop) begin errors++; $display("FAIL illegal_clamp_commit got %h exp %h", crop_all, exp_crop); end
`else
    checks++; if ({cfg_err, cfg_bus.cfg_ready, cfg_pending} !== 3'b110) begin errors++; $display("FAIL illegal_err got %b exp 110", {cfg_err, cfg_bus.cfg_ready, cfg_pending}); end
    checks++; if (crop_all !== exp_crop) begin errors++; $display("FAIL illegal_unchanged got %h exp %h", crop_all, exp_crop); end
    tick();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse got %b exp 0", cfg_err); end
`endif
  endtask

  task automatic test_flush_sof();
    send_req(16'd10, 16'd10, 16'd20, 16'd20);
    tick();
    cfg_flush = 1'b1;
    sof = 1'b1;
    tick();
    cfg_flush = 1'b0;
    sof = 1'b0;
    checks++; if ({cfg_applied, cfg_bus.cfg_ready, cfg_pending} !== 3'b010) begin errors++; $display("FAIL flush_flags got %b exp 010", {cfg_applied, cfg_bus.cfg_ready, cfg_pending}); end
    checks++; if (crop_all !== exp_crop) begin errors++; $display("FAIL flush_no_commit got %h exp %h", crop_all, exp_crop); end
  endtask

  task automatic test_sof_in_check();
    send_req(16'd200, 16'd100, 16'd320, 16'd240);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    checks++; if ({cfg_pending, cfg_applied} !== 2'b10) begin errors++; $display("FAIL sofcheck_pending got %b exp 10", {cfg_pending, cfg_applied}); end
    tick();
    checks++; if (crop_all !== exp_crop) begin errors++; $display("FAIL sofcheck_no_commit got %h exp %h", crop_all, exp_crop); end
    sof = 1'b1;
    tick();
    sof = 1'b0;
    exp_crop = {16'd200, 16'd100, 16'd320, 16'd240};
    checks++; if ({crop_all, cfg_applied} !== {exp_crop, 1'b1}) begin errors++; $display("FAIL sofcheck_commit got %h/%b exp %h/1", crop_all, cfg_applied, exp_crop); end
  endtask

  task automatic test_back_to_back();
    send_req(16'd0, 16'd0, 16'd64, 16'd64);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_x = 16'd8;
    cfg_bus.cfg_y = 16'd8;
    cfg_bus.cfg_w = 16'd32;
    cfg_bus.cfg_h = 16'd32;
    tick();
    tick();
    checks++; if ({cfg_pending, cfg_bus.cfg_ready} !== 2'b10) begin errors++; $display("FAIL b2b_hold got %b exp 10", {cfg_pending, cfg_bus.cfg_ready}); end
    sof = 1'b1;
    tick();
    sof = 1'b0;
    checks++; if (crop_all !== {16'd0, 16'd0, 16'd64, 16'd64}) begin errors++; $display("FAIL b2b_first got %h exp %h", crop_all, {16'd0, 16'd0, 16'd64, 16'd64}); end
    tick();
    cfg_bus.cfg_valid = 1'b0;
    checks++; if ({cfg_bus.cfg_ready, cfg_pending} !== 2'b00) begin errors++; $display("FAIL b2b_accept got %b exp 00", {cfg_bus.cfg_ready, cfg_pending}); end
    tick();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    exp_crop = {16'd8, 16'd8, 16'd32, 16'd32};
    checks++; if (crop_all !== exp_crop) begin errors++; $display("FAIL b2b_second got %h exp %h", crop_all, exp_crop); end
  endtask

  task automatic test_reset_pending();
    send_req(16'd300, 16'd300, 16'd100, 16'd100);
    tick();
    #2;
    rst = 1'b0;
    #1;
    exp_crop = {16'd0, 16'd0, 16'd1920, 16'd1080};
    checks++; if (crop_all !== exp_crop) begin errors++; $display("FAIL rstpend_crop got %h exp %h", crop_all, exp_crop); end
    checks++; if ({cfg_pending, cfg_bus.cfg_ready} !== 2'b00) begin errors++; $display("FAIL rstpend_flags got %b exp 00", {cfg_pending, cfg_bus.cfg_ready}); end
    tick();
    rst = 1'b1;
    tick();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    checks++; if ({crop_all, cfg_applied} !== {exp_crop, 1'b0}) begin errors++; $display("FAIL rstpend_no_commit got %h/%b exp %h/0", crop_all, cfg_applied, exp_crop); end
  endtask

  task automatic test_wrap();
    send_req(16'd65535, 16'd0, 16'd1, 16'd1);
    tick();
`ifdef CROP_VIDEO_CFG_CLAMP_EN
    checks++; if ({cfg_err, cfg_pending} !== 2'b11) begin errors++; $display("FAIL wrap_clamp_flags got %b exp 11", {cfg_err, cfg_pending}); end
    sof = 1'b1;
    tick();
    sof = 1'b0;
    exp_crop = {16'd1919, 16'd0, 16'd1, 16'd1};
    checks++; if (crop_all !== exp_crop) begin errors++; $display("FAIL wrap_clamp_commit got %h exp %h", crop_all, exp_crop); end
`else
    checks++; if ({cfg_err, cfg_pending, cfg_bus.cfg_ready} !== 3'b101) begin errors++; $display("FAIL wrap_reject got %b exp 101", {cfg_err, cfg_pending, cfg_bus.cfg_ready}); end
    checks++; if (crop_all !== exp_crop) begin errors++; $display("FAIL wrap_unchanged got %h exp %h", crop_all, exp_crop); end
`endif
  endtask

  initial begin
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_x = 16'd0;
    cfg_bus.cfg_y = 16'd0;
    cfg_bus.cfg_w = 16'd0;
    cfg_bus.cfg_h = 16'd0;
    exp_crop = 64'd0;
    test_reset();
    test_basic();
    test_illegal();
    test_flush_sof();
    test_sof_in_check();
    test_back_to_back();
    test_reset_pending();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
